// File: rtl/axi_lite_regfile.sv
// axi_lite_regfile: parametrised AXI4-Lite slave register file with read-only slots, error responses and write pulses
module axi_lite_regfile #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter logic [NUM_REGS-1:0] RO_MASK = '0,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] ro_in,
  output logic [NUM_REGS-1:0]            wr_pulse
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int AL = $clog2(STRB_W);
  localparam int IW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  logic aw_held_q, aw_held_d, w_held_q, w_held_d, bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
  logic [DATA_WIDTH-1:0] w_data_q, w_data_d, rdata_q, rdata_d;
  logic [STRB_W-1:0] w_strb_q, w_strb_d;
  logic [1:0] bresp_q, bresp_d, rresp_q, rresp_d;
  logic [NUM_REGS-1:0] wr_pulse_q, wr_pulse_d;
  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] ro_arr [NUM_REGS];
  logic commit, ar_hs, w_hit, r_hit, w_ro, r_ro;
  logic [IW-1:0] w_idx, r_idx;

  function automatic logic hit(input logic [ADDR_WIDTH-1:0] a);
    return a >= BASE_ADDR && ((a - BASE_ADDR) >> AL) < ADDR_WIDTH'(NUM_REGS);
  endfunction

  function automatic logic [IW-1:0] idx_of(input logic [ADDR_WIDTH-1:0] a);
    return IW'((a - BASE_ADDR) >> AL);
  endfunction

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_slot
    assign reg_out[i*DATA_WIDTH +: DATA_WIDTH] = regs_q[i];
    assign ro_arr[i] = ro_in[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign AWREADY = !aw_held_q;
  assign WREADY = !w_held_q;
  assign ARREADY = !rvalid_q;
  assign BVALID = bvalid_q;
  assign BRESP = bresp_q;
  assign RVALID = rvalid_q;
  assign RDATA = rdata_q;
  assign RRESP = rresp_q;
  assign wr_pulse = wr_pulse_q;

  always_comb begin
    w_idx = idx_of(aw_addr_q);
    r_idx = idx_of(ARADDR);
    w_hit = hit(aw_addr_q);
    r_hit = hit(ARADDR);
    w_ro = RO_MASK[w_idx];
    r_ro = RO_MASK[r_idx];
    commit = aw_held_q && w_held_q && (!bvalid_q || BREADY);
    ar_hs = ARVALID && !rvalid_q;
    aw_held_d = aw_held_q ? !commit : AWVALID;
    w_held_d = w_held_q ? !commit : WVALID;
    aw_addr_d = (AWVALID && !aw_held_q) ? AWADDR : aw_addr_q;
    w_data_d = (WVALID && !w_held_q) ? WDATA : w_data_q;
    w_strb_d = (WVALID && !w_held_q) ? WSTRB : w_strb_q;
    bvalid_d = commit || (bvalid_q && !BREADY);
    bresp_d = !commit ? bresp_q : !w_hit ? 2'b11 : w_ro ? 2'b10 : 2'b00;
    regs_d = regs_q;
    wr_pulse_d = '0;
    if (commit && w_hit && !w_ro) begin
      wr_pulse_d[w_idx] = 1'b1;
      for (int b = 0; b < STRB_W; b++)
        regs_d[w_idx][b*8 +: 8] = w_strb_q[b] ? w_data_q[b*8 +: 8] : regs_q[w_idx][b*8 +: 8];
    end
    rvalid_d = ar_hs || (rvalid_q && !RREADY);
    rdata_d = !ar_hs ? rdata_q : !r_hit ? '0 : r_ro ? ro_arr[r_idx] : regs_q[r_idx];
    rresp_d = !ar_hs ? rresp_q : r_hit ? 2'b00 : 2'b11;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      aw_held_q <= 1'b0;
      w_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q <= 2'b00;
      rvalid_q <= 1'b0;
      rdata_q <= '0;
      rresp_q <= 2'b00;
      wr_pulse_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RO_MASK[i] ? '0 : RESET_VALUE;
    end else begin
      aw_held_q <= aw_held_d;
      w_held_q <= w_held_d;
      aw_addr_q <= aw_addr_d;
      w_data_q <= w_data_d;
      w_strb_q <= w_strb_d;
      bvalid_q <= bvalid_d;
      bresp_q <= bresp_d;
      rvalid_q <= rvalid_d;
      rdata_q <= rdata_d;
      rresp_q <= rresp_d;
      wr_pulse_q <= wr_pulse_d;
      regs_q <= regs_d;
    end
  end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// tb_axi_lite_regfile: table, directed and randomized checks of axi_lite_regfile against a behavioural model
module tb_axi_lite_regfile;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int n_err = 0;
  int n_chk = 0;

  logic rst_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic awvalid, awready, wvalid, wready, bvalid, bready, arvalid, arready, rvalid, rready;
  logic [3:0] wstrb;
  logic [1:0] bresp, rresp;
  logic [511:0] reg_out, ro_in;
  logic [15:0] wr_pulse;

  logic rst1_n;
  logic [31:0] awaddr1, araddr1;
  logic [63:0] wdata1, rdata1;
  logic [7:0] wstrb1;
  logic awvalid1, awready1, wvalid1, wready1, bvalid1, bready1, arvalid1, arready1, rvalid1, rready1;
  logic [1:0] bresp1, rresp1;
  logic [255:0] reg_out1, ro_in1;
  logic [3:0] wr_pulse1;

  localparam logic [63:0] RV1 = 64'h5A5A5A5A5A5A5A5A;

  axi_lite_regfile #(.RO_MASK(16'h0002)) dut (
    .clk(clk), .rst_n(rst_n),
    .AWADDR(awaddr), .AWVALID(awvalid), .AWREADY(awready),
    .WDATA(wdata), .WSTRB(wstrb), .WVALID(wvalid), .WREADY(wready),
    .BRESP(bresp), .BVALID(bvalid), .BREADY(bready),
    .ARADDR(araddr), .ARVALID(arvalid), .ARREADY(arready),
    .RDATA(rdata), .RRESP(rresp), .RVALID(rvalid), .RREADY(rready),
    .reg_out(reg_out), .ro_in(ro_in), .wr_pulse(wr_pulse)
  );

  axi_lite_regfile #(.DATA_WIDTH(64), .NUM_REGS(4), .BASE_ADDR(32'h100), .RESET_VALUE(RV1)) dut1 (
    .clk(clk), .rst_n(rst1_n),
    .AWADDR(awaddr1), .AWVALID(awvalid1), .AWREADY(awready1),
    .WDATA(wdata1), .WSTRB(wstrb1), .WVALID(wvalid1), .WREADY(wready1),
    .BRESP(bresp1), .BVALID(bvalid1), .BREADY(bready1),
    .ARADDR(araddr1), .ARVALID(arvalid1), .ARREADY(arready1),
    .RDATA(rdata1), .RRESP(rresp1), .RVALID(rvalid1), .RREADY(rready1),
    .reg_out(reg_out1), .ro_in(ro_in1), .wr_pulse(wr_pulse1)
  );

  logic [31:0] m_regs [16];

  function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int i;
    i = int'(a >> 2);
    if (a >= 32'h40) return 2'b11;
    if (i == 1) return 2'b10;
    for (int b = 0; b < 4; b++) if (s[b]) m_regs[i][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  function automatic logic [1:0] m_read(input logic [31:0] a, output logic [31:0] d);
    int i;
    i = int'(a >> 2);
    d = 32'h0;
    if (a >= 32'h40) return 2'b11;
    d = (i == 1) ? ro_in[63:32] : m_regs[i];
    return 2'b00;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timed_out(input string name);
    n_chk++;
    n_err++;
    $display("FAIL %s: no handshake within bound, required one", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg_out(input string name);
    int bad = 0;
    for (int i = 0; i < 16; i++) if (reg_out[i*32 +: 32] !== (i == 1 ? 32'h0 : m_regs[i])) bad++;
    chk(name, 64'(bad), 64'd0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input int aw_dly,
                    input int w_dly, output logic [1:0] resp, output logic [15:0] pulse);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int cyc = 0;
    resp = 2'bxx;
    pulse = 'x;
    awaddr = a;
    wdata = d;
    wstrb = s;
    bready = 1'b1;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && cyc >= aw_dly;
      wvalid = !w_done && cyc >= w_dly;
      aw_hs = awvalid && awready;
      w_hs = wvalid && wready;
      tick();
      aw_done |= aw_hs;
      w_done |= w_hs;
      cyc++;
    end
    awvalid = 1'b0;
    wvalid = 1'b0;
    if (!(aw_done && w_done)) timed_out("wr_handshake");
    else begin
      chk("bvalid_before_commit", 64'(bvalid), 64'd0);
      tick();
      chk("bvalid_latency", 64'(bvalid), 64'd1);
      resp = bresp;
      pulse = wr_pulse;
      tick();
      chk("pulse_one_cycle", 64'(wr_pulse), 64'd0);
      chk("bvalid_clear", 64'(bvalid), 64'd0);
    end
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp);
    bit hs = 0;
    int cyc = 0;
    d = 'x;
    resp = 'x;
    araddr = a;
    rready = 1'b1;
    while (!hs && cyc < 20) begin
      arvalid = 1'b1;
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    if (!hs) timed_out("rd_handshake");
    else begin
      chk("rvalid_latency", 64'(rvalid), 64'd1);
      d = rdata;
      resp = rresp;
      tick();
      chk("rvalid_clear", 64'(rvalid), 64'd0);
    end
  endtask

  task automatic wr1(input logic [31:0] a, input logic [63:0] d, input logic [7:0] s, output logic [1:0] resp);
    int cyc = 0;
    awaddr1 = a;
    wdata1 = d;
    wstrb1 = s;
    bready1 = 1'b1;
    awvalid1 = 1'b1;
    wvalid1 = 1'b1;
    tick();
    awvalid1 = 1'b0;
    wvalid1 = 1'b0;
    while (!bvalid1 && cyc < 10) begin
      tick();
      cyc++;
    end
    resp = bresp1;
    if (!bvalid1) timed_out("wr1_bvalid");
    tick();
  endtask

  task automatic rd1(input logic [31:0] a, output logic [63:0] d, output logic [1:0] resp);
    int cyc = 0;
    araddr1 = a;
    rready1 = 1'b1;
    arvalid1 = 1'b1;
    tick();
    arvalid1 = 1'b0;
    while (!rvalid1 && cyc < 10) begin
      tick();
      cyc++;
    end
    d = rdata1;
    resp = rresp1;
    if (!rvalid1) timed_out("rd1_rvalid");
    tick();
  endtask

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  initial begin
    logic [1:0] resp, er;
    logic [15:0] pulse, exp_pulse;
    logic [31:0] a, d, ed;
    logic [3:0] s;
    logic [63:0] d1;
    int cnt, bad;
    tbl[0]  = '{1'b1, 32'h10, 32'hCAFEBABE, 4'hF, 2'b00, 32'h0};
    tbl[1]  = '{1'b0, 32'h10, 32'h0,        4'h0, 2'b00, 32'hCAFEBABE};
    tbl[2]  = '{1'b1, 32'h14, 32'h00000000, 4'hF, 2'b00, 32'h0};
    tbl[3]  = '{1'b1, 32'h14, 32'h000000FF, 4'h1, 2'b00, 32'h0};
    tbl[4]  = '{1'b1, 32'h14, 32'hAB000000, 4'h8, 2'b00, 32'h0};
    tbl[5]  = '{1'b0, 32'h14, 32'h0,        4'h0, 2'b00, 32'hAB0000FF};
    tbl[6]  = '{1'b1, 32'h04, 32'hFFFFFFFF, 4'hF, 2'b10, 32'h0};
    tbl[7]  = '{1'b0, 32'h04, 32'h0,        4'h0, 2'b00, 32'h12345678};
    tbl[8]  = '{1'b1, 32'h40, 32'h11111111, 4'hF, 2'b11, 32'h0};
    tbl[9]  = '{1'b0, 32'h40, 32'h0,        4'h0, 2'b11, 32'h0};
    tbl[10] = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[11] = '{1'b1, 32'h3F, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0};
    tbl[12] = '{1'b0, 32'h3C, 32'h0,        4'h0, 2'b00, 32'hDEADBEEF};
    tbl[13] = '{1'b1, 32'h18, 32'h12345678, 4'h0, 2'b00, 32'h0};
    tbl[14] = '{1'b0, 32'h18, 32'h0,        4'h0, 2'b00, 32'h0};
    tbl[15] = '{1'b0, 32'h44, 32'h0,        4'h0, 2'b11, 32'h0};
    for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
    rst_n = 1'b0;
    rst1_n = 1'b0;
    {awvalid, wvalid, arvalid, awvalid1, wvalid1, arvalid1} = '0;
    {bready, rready, bready1, rready1} = '1;
    {awaddr, wdata, wstrb, araddr, awaddr1, wdata1, wstrb1, araddr1} = '0;
    ro_in = {16{32'hA5A50F0F}};
    ro_in[63:32] = 32'h12345678;
    ro_in1 = {4{64'hFFFF0000FFFF0000}};
    #1;
    tick();
    tick();
    chk("reset_ready", 64'({awready, wready, arready}), 64'b111);
    chk("reset_valid_resp", 64'({bvalid, rvalid, bresp, rresp}), 64'd0);
    chk("reset_rdata_pulse", {rdata, 16'h0, wr_pulse}, 64'd0);
    check_reg_out("reset_reg_out");
    rst_n = 1'b1;
    tick();
    chk("post_reset_ready", 64'({awready, wready, arready, bvalid, rvalid}), 64'b11100);

    for (int i = 0; i < NV; i++) begin
      if (tbl[i].wr) begin
        exp_pulse = (tbl[i].resp == 2'b00) ? 16'd1 << tbl[i].addr[5:2] : 16'd0;
        wr(tbl[i].addr, tbl[i].data, tbl[i].strb, 0, 0, resp, pulse);
        chk($sformatf("tbl%0d_bresp", i), 64'(resp), 64'(tbl[i].resp));
        chk($sformatf("tbl%0d_pulse", i), 64'(pulse), 64'(exp_pulse));
        void'(m_write(tbl[i].addr, tbl[i].data, tbl[i].strb));
      end else begin
        rd(tbl[i].addr, d, resp);
        chk($sformatf("tbl%0d_rresp", i), 64'(resp), 64'(tbl[i].resp));
        chk($sformatf("tbl%0d_rdata", i), 64'(d), 64'(tbl[i].rdata));
      end
    end
    chk("slot4_cafebabe", 64'(reg_out[159:128]), 64'hCAFEBABE);
    check_reg_out("tbl_reg_out");

    wr(32'h08, 32'h11223344, 4'hF, 3, 0, resp, pulse);
    chk("w_first_bresp", 64'(resp), 64'd0);
    chk("w_first_pulse", 64'(pulse), 64'h0004);
    void'(m_write(32'h08, 32'h11223344, 4'hF));
    rd(32'h08, d, resp);
    chk("w_first_rdata", 64'(d), 64'h11223344);
    wr(32'h08, 32'h55667788, 4'hF, 0, 3, resp, pulse);
    chk("aw_first_bresp", 64'(resp), 64'd0);
    void'(m_write(32'h08, 32'h55667788, 4'hF));
    rd(32'h08, d, resp);
    chk("aw_first_rdata", 64'(d), 64'h55667788);

    bready = 1'b0;
    awaddr = 32'h10;
    wdata = 32'h0BADF00D;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    tick();
    awaddr = 32'h18;
    wdata = 32'h600DCAFE;
    chk("bp_held_ready", 64'({awready, wready}), 64'd0);
    tick();
    chk("bp_first_commit", 64'({bvalid, bresp, wr_pulse}), {45'd0, 1'b1, 2'b00, 16'h0010});
    void'(m_write(32'h10, 32'h0BADF00D, 4'hF));
    chk("bp_ready_free", 64'({awready, wready}), 64'b11);
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_stable", 64'({bvalid, bresp, awready, wready, wr_pulse != 16'h0}), 64'b100000);
      chk("bp_no_early_write", 64'(reg_out[223:192]), 64'(m_regs[6]));
      tick();
    end
    bready = 1'b1;
    tick();
    chk("bp_second_commit", 64'({bvalid, bresp, wr_pulse}), {45'd0, 1'b1, 2'b00, 16'h0040});
    chk("bp_second_data", 64'(reg_out[223:192]), 64'h600DCAFE);
    void'(m_write(32'h18, 32'h600DCAFE, 4'hF));
    tick();
    chk("bp_bvalid_clear", 64'(bvalid), 64'd0);

    rready = 1'b0;
    araddr = 32'h10;
    arvalid = 1'b1;
    tick();
    araddr = 32'h14;
    for (int i = 0; i < 5; i++) begin
      chk("rp_stable", 64'({rvalid, rresp, rdata, arready}), {28'd0, 1'b1, 2'b00, 32'h0BADF00D, 1'b0});
      tick();
    end
    arvalid = 1'b0;
    rready = 1'b1;
    tick();
    chk("rp_rvalid_clear", 64'(rvalid), 64'd0);

    awaddr = 32'h10;
    wdata = 32'hFEEDFACE;
    wstrb = 4'hF;
    awvalid = 1'b1;
    wvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid = 1'b0;
    araddr = 32'h10;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("coll_rdata_old", 64'({rvalid, rdata}), {31'd0, 1'b1, 32'h0BADF00D});
    chk("coll_reg_new", 64'({bvalid, reg_out[159:128]}), {31'd0, 1'b1, 32'hFEEDFACE});
    void'(m_write(32'h10, 32'hFEEDFACE, 4'hF));
    tick();
    rd(32'h10, d, resp);
    chk("coll_reread", 64'(d), 64'hFEEDFACE);

    araddr = 32'h10;
    arvalid = 1'b1;
    cnt = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      cnt += int'(rvalid);
    end
    arvalid = 1'b0;
    chk("rd_throughput", 64'(cnt), 64'd3);
    tick();

    for (int k = 0; k < 60; k++) begin
      a = 32'($urandom_range(0, 32'h4F));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        wr(a, d, s, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), resp, pulse);
        er = m_write(a, d, s);
        exp_pulse = (er == 2'b00) ? 16'd1 << a[5:2] : 16'd0;
        chk($sformatf("rnd%0d_bresp", k), 64'(resp), 64'(er));
        chk($sformatf("rnd%0d_pulse", k), 64'(pulse), 64'(exp_pulse));
      end else begin
        ro_in[63:32] = $urandom;
        rd(a, d, resp);
        er = m_read(a, ed);
        chk($sformatf("rnd%0d_rresp", k), 64'(resp), 64'(er));
        chk($sformatf("rnd%0d_rdata", k), 64'(d), 64'(ed));
      end
    end
    check_reg_out("rnd_reg_out");

    chk("p_reset_ready", 64'({awready1, wready1, arready1, bvalid1, rvalid1}), 64'b11100);
    rst1_n = 1'b1;
    tick();
    bad = 0;
    for (int i = 0; i < 4; i++) if (reg_out1[i*64 +: 64] !== RV1) bad++;
    chk("p_reset_value", 64'(bad), 64'd0);
    rd1(32'h118, d1, resp);
    chk("p_rd_118", {d1[61:0], resp}, {RV1[61:0], 2'b00});
    rd1(32'h120, d1, resp);
    chk("p_rd_120", {d1[61:0], resp}, 64'd3);
    rd1(32'hF8, d1, resp);
    chk("p_rd_below_base", {d1[61:0], resp}, 64'd3);
    wr1(32'h100, 64'h0123456789ABCDEF, 8'hFF, resp);
    chk("p_wr_100_resp", 64'(resp), 64'd0);
    chk("p_wr_100_data", reg_out1[63:0], 64'h0123456789ABCDEF);
    wr1(32'h108, 64'hFFFFFFFFFFFFFFFF, 8'hF0, resp);
    rd1(32'h10C, d1, resp);
    chk("p_strobe_rdata", d1, 64'hFFFFFFFF5A5A5A5A);

    awaddr1 = 32'h110;
    awvalid1 = 1'b1;
    tick();
    awvalid1 = 1'b0;
    chk("p_aw_held", 64'(awready1), 64'd0);
    rst1_n = 1'b0;
    tick();
    chk("p_midreset_outputs", 64'({awready1, wready1, arready1, bvalid1, rvalid1, bresp1, rresp1, wr_pulse1}), 64'b11100_00_00_0000);
    chk("p_midreset_rdata", rdata1, 64'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) if (reg_out1[i*64 +: 64] !== RV1) bad++;
    chk("p_midreset_regs", 64'(bad), 64'd0);
    rst1_n = 1'b1;
    wdata1 = 64'hDEADBEEF00C0FFEE;
    wstrb1 = 8'hFF;
    wvalid1 = 1'b1;
    tick();
    wvalid1 = 1'b0;
    tick();
    tick();
    chk("p_no_commit", 64'({bvalid1, wr_pulse1, wready1}), 64'd0);
    chk("p_slot2_kept", reg_out1[191:128], RV1);
    awaddr1 = 32'h110;
    awvalid1 = 1'b1;
    tick();
    awvalid1 = 1'b0;
    tick();
    chk("p_late_commit", 64'({bvalid1, bresp1, wr_pulse1}), 64'b1_00_0100);
    chk("p_late_data", reg_out1[191:128], 64'hDEADBEEF00C0FFEE);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/axi_lite_regfile.md
# axi_lite_regfile

Parametrised AXI4-Lite slave register file: the successor to the simple AXI-Lite slave, generalised in data width, register count and base address. It adds independent AW/W acceptance, per-register read-only mapping, SLVERR/DECERR responses and a user-side register/pulse interface. It sits behind `axi_lite_master` (or an interconnect) and exposes control/status registers to the surrounding logic.

## Interface
- `ADDR_WIDTH`, 32: AXI address width.
- `DATA_WIDTH`, 32: data width. Must be a multiple of 8; `STRB_W = DATA_WIDTH/8`.
- `NUM_REGS`, 16: number of registers (≥1).
- `BASE_ADDR`, 0: byte address of register 0. Must be aligned to `STRB_W`.
- `RO_MASK`, 0 (`NUM_REGS` bits): bit i = 1 makes register i read-only.
- `RESET_VALUE`, 0 (`DATA_WIDTH` bits): reset value of every writable register.

Ports:
- `clk` in 1: the single clock.
- `rst_n` in 1: synchronous, active-low reset.
- `AWADDR` in ADDR_WIDTH, `AWVALID` in 1, `AWREADY` out 1: write address channel.
- `WDATA` in DATA_WIDTH, `WSTRB` in STRB_W, `WVALID` in 1, `WREADY` out 1: write data channel.
- `BRESP` out 2, `BVALID` out 1, `BREADY` in 1: write response channel.
- `ARADDR` in ADDR_WIDTH, `ARVALID` in 1, `ARREADY` out 1: read address channel.
- `RDATA` out DATA_WIDTH, `RRESP` out 2, `RVALID` out 1, `RREADY` in 1: read data channel.
- `reg_out` out NUM_REGS*DATA_WIDTH: current values of all registers, flattened. Register i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`. Read-only slots drive 0.
- `ro_in` in NUM_REGS*DATA_WIDTH: values returned on reads of read-only registers, same layout.
- `wr_pulse` out NUM_REGS: one-cycle strobe for register i on a committed OKAY write.

## Operation
- **Address decode:**
  - `idx = (addr - BASE_ADDR) >> log2(STRB_W)`; the low byte-offset bits are ignored.
  - An access is out of range if `addr < BASE_ADDR` or `idx >= NUM_REGS`.
- **Write path:**
  - Two holding flags, `aw_held` and `w_held`. `AWREADY = !aw_held` and `WREADY = !w_held`; both are combinational from the flags.
  - An AW handshake latches the address and sets `aw_held`. A W handshake latches data and strobe and sets `w_held`. AW and W may arrive in either order or in the same cycle.
  - Commit condition: `aw_held && w_held && (!BVALID || BREADY)`. At the commit edge:
    - Evaluate the response.
    - Update the register only on OKAY.
    - Set `BVALID`, load `BRESP`, clear both flags.
  - The register update uses byte lanes: for each b with `WSTRB[b]=1`, byte b takes `WDATA` byte b. All other bytes are kept.
  - `WSTRB=0` is an OKAY write with no data change; `wr_pulse` still fires.
  - BRESP values:
    - 2'b00 OKAY: in range and writable.
    - 2'b10 SLVERR: in range but read-only; no update, no pulse.
    - 2'b11 DECERR: out of range; no update, no pulse.
  - `BVALID` clears on `BVALID && BREADY` unless a new commit happens on that same edge.
- **Read path:**
  - `ARREADY = !RVALID`.
  - On an AR handshake: register `RDATA` and `RRESP`, and set `RVALID`.
  - Read data source:
    - Writable register: its stored value.
    - Read-only register: the `ro_in` slot sampled at the handshake edge; RRESP OKAY.
    - Out of range: `RDATA=0`, RRESP DECERR.
  - `RDATA`/`RRESP` stay stable while `RVALID && !RREADY`. `RVALID` clears on `RREADY`.
- **Read/write collision:** the read and write paths are independent. If a read handshake and a write commit to the same register land on the same edge, the read returns the pre-write value.
- **Reset** (`rst_n=0` at a clock edge):
  - Writable registers return to `RESET_VALUE`.
  - Holding flags clear, so any partial write is discarded.
  - `BVALID`, `RVALID`, `wr_pulse`, `BRESP`, `RRESP` and `RDATA` go to 0.
  - Reset takes effect even in the middle of a transaction.

## Timing
- **Output values during and after reset:** `AWREADY=WREADY=ARREADY=1`, `BVALID=RVALID=0`, `BRESP=RRESP=0`, `RDATA=0`, `wr_pulse=0`, `reg_out=RESET_VALUE` (read-only slots 0).
- **Write latency:**
  - If AW and W handshake at edge N, commit happens at edge N+1. From N+1: `BVALID=1`, `reg_out` is updated, and `wr_pulse` is high for exactly one cycle.
  - If AW and W handshake on different edges, commit happens one edge after the later of the two.
  - At most one write is pending. While `BVALID` is stalled, at most one further AW and one further W are absorbed, then `AWREADY`/`WREADY` drop.
- **Read latency:**
  - AR handshake at edge N gives `RVALID=1` from N.
  - With `RREADY` held high, throughput is one read every 2 cycles.
- **Response ordering:** a B response is never produced before both its AW and W have handshaken. `BRESP` is stable while `BVALID && !BREADY`.

## Test plan
- **Write/read, default parameters:** write 0xCAFEBABE to 0x10 with `WSTRB=4'hF`. Expect BRESP=00, a one-cycle `wr_pulse[4]`, and `reg_out` slot 4 = 0xCAFEBABE. Reading 0x10 then returns 0xCAFEBABE with RRESP=00 one cycle after the AR handshake.
- **Byte strobes:** write 0x00000000, then write 0x000000FF with `WSTRB=4'b0001`, then 0xAB000000 with `WSTRB=4'b1000`. A read of the register returns 0xAB0000FF.
- **Channel ordering:** for address 0x08, present W three cycles before AW, then repeat with AW before W. Expect one BVALID per write, asserted one cycle after the later handshake, and correct data both times.
- **Error responses** (`RO_MASK=16'h0002`, `ro_in` slot 1 = 0x12345678):
  - Write to 0x04: BRESP=10, no pulse.
  - Read of 0x04: returns 0x12345678, RRESP=00.
  - Access to 0x40: BRESP=11, and a read returns 0 with RRESP=11.
- **Backpressure and collision:** hold BREADY and RREADY low for 5 cycles and check BVALID/RVALID and their payloads stay stable. Check AWREADY/WREADY drop after the second buffered AW/W. On a same-edge read and write of 0x10, the read returns the old value.
- **Parameters and reset:**
  - Build with `DATA_WIDTH=64`, `NUM_REGS=4`, `BASE_ADDR=0x100`, `RESET_VALUE` = 0x5A5A5A5A5A5A5A5A.
  - Read 0x118: returns the reset value. Read 0x120: DECERR.
  - Assert `rst_n=0` for one cycle between AW and W of a write: no commit, all outputs at their reset values.
